// File: rtl/count_display.sv
// -----------------------------------------------------------------------------
// count_display
//
// Converts a 7-bit binary count (0..127) into two 7-segment digits using a
// sequential double-dabble converter, one shift step per clock.
//
// A conversion starts whenever the FSM is idle and the incoming count differs
// from the value currently shown. The input is captured at the start, so
// later changes on `times` do not disturb a conversion in flight. The display
// registers change only on the final UPDATE edge. Because the FSM compares
// again after every update, the last stable input always ends up displayed.
//
// Parameters
//   BLANK_LEADING : 1 = blank the tens digit for values below 10
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous reset, active-low
//   times      in   7  binary count from the upstream press counter
//   seg_led_1  out  9  tens digit   {enable_n, dp(hundreds), g..a}
//   seg_led_2  out  9  units digit  {enable_n, dp(always 0), g..a}
//   busy       out  1  high while a conversion is in progress
// -----------------------------------------------------------------------------
module count_display #(
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] times,
    output logic [8:0] seg_led_1,
    output logic [8:0] seg_led_2,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Seven input bits need seven shift steps; the counter runs 0..6.
    localparam logic [2:0] LAST_STEP = 3'd6;

    // After reset the display shows 0, with the tens digit blanked if enabled.
    localparam logic [8:0] SEG1_RST = (BLANK_LEADING != 32'sd0) ? 9'h000 : 9'h03F;
    localparam logic [8:0] SEG2_RST = 9'h03F;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    // Codes 10..15 cannot occur for inputs up to 127; they map to dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Add 3 to a BCD nibble of 5 or more so that the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nibble);
        logic [3:0] adj;
        if (nibble >= 4'd5) begin
            adj = nibble + 4'd3;
        end else begin
            adj = nibble;
        end
        return adj;
    endfunction

    // One double-dabble step. Returns {bcd_next[8:0], shift_next[6:0]}.
    // The 16-bit chain is {hundreds, tens, units, shift register}; the old
    // hundreds bit falls off the top, which is safe since it only becomes
    // set on the final shift for inputs 100..127.
    function automatic logic [15:0] dabble_step(input logic [8:0] bcd,
                                                input logic [6:0] sh);
        logic [15:0] chain;
        chain = {bcd[8], dabble_adjust(bcd[7:4]), dabble_adjust(bcd[3:0]), sh};
        return {chain[14:0], 1'b0};
    endfunction

    state_t     state_r;
    logic [6:0] shift_r;     // remaining binary bits of the captured value
    logic [8:0] bcd_r;       // {hundreds bit, tens nibble, units nibble}
    logic [2:0] iter_r;      // number of shift steps already done
    logic [6:0] val_r;       // value captured for the conversion in flight
    logic [6:0] cur_val_r;   // value currently on the display

    logic [15:0] step_s;
    logic [8:0]  seg1_next_s;
    logic [8:0]  seg2_next_s;

    // Next double-dabble step of the working registers.
    always_comb begin
        step_s = dabble_step(bcd_r, shift_r);
    end

    // Display patterns for the finished BCD result, with leading-zero blanking.
    always_comb begin
        seg1_next_s = 9'h000;
        seg2_next_s = {2'b00, seg_encode(bcd_r[3:0])};
        if ((BLANK_LEADING != 32'sd0) && (bcd_r[8] == 1'b0) && (bcd_r[7:4] == 4'd0)) begin
            seg1_next_s = 9'h000;
        end else begin
            // DP lights as the hundreds indicator; 100..109 show a tens 0.
            seg1_next_s = {1'b0, bcd_r[8], seg_encode(bcd_r[7:4])};
        end
    end

    // Conversion FSM with registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            shift_r   <= 7'd0;
            bcd_r     <= 9'd0;
            iter_r    <= 3'd0;
            val_r     <= 7'd0;
            cur_val_r <= 7'd0;
            busy      <= 1'b0;
            seg_led_1 <= SEG1_RST;
            seg_led_2 <= SEG2_RST;
        end else begin
            case (state_r)
                IDLE: begin
                    if (times != cur_val_r) begin
                        shift_r <= times;
                        val_r   <= times;
                        bcd_r   <= 9'd0;
                        iter_r  <= 3'd0;
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    bcd_r   <= step_s[15:7];
                    shift_r <= step_s[6:0];
                    iter_r  <= iter_r + 3'd1;
                    if (iter_r == LAST_STEP) begin
                        state_r <= UPDATE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                UPDATE: begin
                    seg_led_1 <= seg1_next_s;
                    seg_led_2 <= seg2_next_s;
                    cur_val_r <= val_r;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    // Unreachable encoding: recover to a quiet idle state.
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
